// File: rtl/i2c_config_seq.sv
// rtl/i2c_config_seq.sv - walks a register LUT out through an I2C master, with per-word NACK retry
module i2c_config_seq #(
   parameter int         LUT_SIZE   = 10,
   parameter int         IDX_W      = 6,
   parameter logic [7:0] DEV_ADDR   = 8'h34,
   parameter int         MAX_RETRY  = 3,
   parameter int         GAP_CYCLES = 4,
   parameter int         AUTO_START = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mend,
   input  logic             mack,
   input  logic [15:0]      lut_data,
   output logic [IDX_W-1:0] lut_index,
   output logic             mgo,
   output logic [23:0]      i2c_data,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [IDX_W-1:0] err_index
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_GAP,
      S_DONE,
      S_ERROR
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LUT_SIZE - 1);
   localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);
   localparam logic [7:0]       GAP_LAST  = 8'(GAP_CYCLES - 1);
   localparam state_t           NEXT_XFER = (GAP_CYCLES == 0) ? S_LOAD : S_GAP;

   state_t     state;
   logic [3:0] retry;
   logic [7:0] gap_cnt;
   logic       first_cycle;
   logic       launch;

   // first_cycle is high only on the first clock after reset release
   assign launch = start || ((AUTO_START != 0) && first_cycle);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         retry       <= '0;
         gap_cnt     <= '0;
         first_cycle <= 1'b1;
         lut_index   <= '0;
         mgo         <= 1'b0;
         i2c_data    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_index   <= '0;
      end else begin
         first_cycle <= 1'b0;
         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (launch) begin
                  lut_index <= '0;
                  retry     <= '0;
                  gap_cnt   <= '0;
                  done      <= 1'b0;
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               i2c_data <= {DEV_ADDR, lut_data};
               mgo      <= 1'b1;
               state    <= S_WAIT;
            end
            S_WAIT: begin
               if (mend) begin
                  mgo <= 1'b0;
                  if (mack) begin
                     if (lut_index == LAST_IDX) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                     end else begin
                        lut_index <= lut_index + IDX_W'(1);
                        retry     <= '0;
                        state     <= NEXT_XFER;
                     end
                  end else if (retry < RETRY_LIM) begin
                     retry <= retry + 4'd1;
                     state <= NEXT_XFER;
                  end else begin
                     err       <= 1'b1;
                     err_index <= lut_index;
                     busy      <= 1'b0;
                     state     <= S_ERROR;
                  end
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  gap_cnt <= '0;
                  state   <= S_LOAD;
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_config_seq.sv
// tb/tb_i2c_config_seq.sv - randomized master model and LUT-walk scoreboard for i2c_config_seq
module tb_i2c_config_seq;

   localparam int LUT_A   = 10;
   localparam int GAP_A   = 4;
   localparam int RETRY_A = 3;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        start_a = 1'b0, mend_a = 1'b0, mack_a = 1'b0;
   logic [15:0] lut_data_a;
   logic [5:0]  lut_index_a, err_index_a;
   logic        mgo_a, busy_a, done_a, err_a;
   logic [23:0] i2c_data_a;

   logic        start_b = 1'b0, mend_b = 1'b0, mack_b = 1'b0;
   logic [15:0] lut_data_b;
   logic [5:0]  lut_index_b, err_index_b;
   logic        mgo_b, busy_b, done_b, err_b;
   logic [23:0] i2c_data_b;

   logic [15:0] tab_a [64];
   logic [15:0] tab_b [64];

   int total = 0;
   int bad   = 0;

   // reference model: which word should be on the wire and how the run ends
   int exp_idx, exp_retry, exp_state;
   int nacks [64];
   int used  [64];

   assign lut_data_a = tab_a[lut_index_a];
   assign lut_data_b = tab_b[lut_index_b];

   always #5 clk = ~clk;

   i2c_config_seq dut_a (
      .clk(clk), .reset(reset), .start(start_a), .mend(mend_a), .mack(mack_a),
      .lut_data(lut_data_a), .lut_index(lut_index_a), .mgo(mgo_a), .i2c_data(i2c_data_a),
      .busy(busy_a), .done(done_a), .err(err_a), .err_index(err_index_a)
   );

   i2c_config_seq #(.LUT_SIZE(1), .GAP_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .mend(mend_b), .mack(mack_b),
      .lut_data(lut_data_b), .lut_index(lut_index_b), .mgo(mgo_b), .i2c_data(i2c_data_b),
      .busy(busy_b), .done(done_b), .err(err_b), .err_index(err_index_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_start();
      exp_idx   = 0;
      exp_retry = 0;
      exp_state = 0;
      for (int i = 0; i < 64; i++) used[i] = 0;
   endtask

   task automatic wait_mgo_a(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (mgo_a) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) check("mgo_a_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_frame_a(input bit ack, output bit ok);
      int lat;
      int gap;
      wait_mgo_a(ok);
      if (!ok) return;
      check("frame_idx", 32'(lut_index_a), 32'(exp_idx));
      check("frame_data", 32'(i2c_data_a), {8'h00, 8'h34, tab_a[exp_idx]});
      check("frame_busy", 32'(busy_a), 32'd1);
      lat = $urandom_range(1, 5);
      for (int i = 0; i < lat; i++) begin
         if ($urandom_range(0, 3) == 0) start_a = 1'b1;
         mack_a = 1'($urandom);
         @(negedge clk);
         start_a = 1'b0;
      end
      check("hold_mgo", 32'(mgo_a), 32'd1);
      check("hold_data", 32'(i2c_data_a), {8'h00, 8'h34, tab_a[exp_idx]});
      mend_a = 1'b1;
      mack_a = ack;
      @(negedge clk);
      mend_a = 1'b0;
      mack_a = 1'($urandom);
      check("mgo_drop", 32'(mgo_a), 32'd0);
      if (ack) begin
         if (exp_idx == LUT_A - 1) exp_state = 1;
         else begin
            exp_idx++;
            exp_retry = 0;
         end
      end else if (exp_retry < RETRY_A) exp_retry++;
      else exp_state = 2;
      if (exp_state == 1) begin
         check("done_set", 32'(done_a), 32'd1);
         check("done_busy", 32'(busy_a), 32'd0);
         check("done_idx", 32'(lut_index_a), 32'(exp_idx));
         check("done_err", 32'(err_a), 32'd0);
      end else if (exp_state == 2) begin
         check("err_set", 32'(err_a), 32'd1);
         check("err_index", 32'(err_index_a), 32'(exp_idx));
         check("err_busy", 32'(busy_a), 32'd0);
         check("err_done", 32'(done_a), 32'd0);
      end else begin
         gap = 0;
         while (!mgo_a && gap < 50) begin
            if (gap == 1) begin
               mend_a = 1'b1;
               mack_a = 1'($urandom);
            end
            @(negedge clk);
            mend_a = 1'b0;
            gap++;
         end
         check("gap_len", 32'(gap), 32'(GAP_A + 1));
      end
   endtask

   task automatic run_seq_a();
      bit ok;
      bit ack;
      bit any_mgo;
      int frames;
      frames = 0;
      while (exp_state == 0 && frames < 200) begin
         ack = (used[exp_idx] >= nacks[exp_idx]);
         if (!ack) used[exp_idx]++;
         do_frame_a(ack, ok);
         if (!ok) return;
         frames++;
      end
      any_mgo = 1'b0;
      for (int i = 0; i < 20; i++) begin
         mend_a = 1'($urandom);
         mack_a = 1'($urandom);
         @(negedge clk);
         if (mgo_a) any_mgo = 1'b1;
      end
      mend_a = 1'b0;
      check("idle_no_mgo", 32'(any_mgo), 32'd0);
      check("hold_done", 32'(done_a), (exp_state == 1) ? 32'd1 : 32'd0);
      check("hold_err", 32'(err_a), (exp_state == 2) ? 32'd1 : 32'd0);
      check("hold_idx", 32'(lut_index_a), 32'(exp_idx));
   endtask

   task automatic restart_a();
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      model_start();
      check("restart_busy", 32'(busy_a), 32'd1);
      check("restart_done", 32'(done_a), 32'd0);
      check("restart_err", 32'(err_a), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      int n;
      for (int i = 0; i < 64; i++) begin
         tab_a[i] = 16'($urandom);
         tab_b[i] = 16'($urandom);
         nacks[i] = 0;
      end

      repeat (3) @(negedge clk);
      check("rst_idx", 32'(lut_index_a), 32'd0);
      check("rst_mgo", 32'(mgo_a), 32'd0);
      check("rst_data", 32'(i2c_data_a), 32'd0);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_err", 32'(err_a), 32'd0);
      check("rst_err_index", 32'(err_index_a), 32'd0);
      check("rst_mgo_b", 32'(mgo_b), 32'd0);

      reset = 1'b1;
      model_start();
      run_seq_a();

      restart_a();
      nacks[4] = 2;
      run_seq_a();
      check("nack2_sent", 32'(used[4]), 32'd2);

      restart_a();
      nacks[4] = 0;
      nacks[7] = 4;
      run_seq_a();
      check("err_word7", 32'(err_index_a), 32'd7);
      check("err_mgo", 32'(mgo_a), 32'd0);
      nacks[7] = 0;

      for (int r = 0; r < 4; r++) begin
         restart_a();
         for (int i = 0; i < 64; i++)
            nacks[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : 0;
         run_seq_a();
      end

      restart_a();
      for (int i = 0; i < 64; i++) nacks[i] = 0;
      for (int i = 0; i < 3; i++) do_frame_a(1'b1, ok);
      wait_mgo_a(ok);
      check("pre_rst_idx", 32'(lut_index_a), 32'd3);
      #2 reset = 1'b0;
      #1;
      check("async_mgo", 32'(mgo_a), 32'd0);
      check("async_busy", 32'(busy_a), 32'd0);
      check("async_idx", 32'(lut_index_a), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      model_start();
      run_seq_a();

      n = 0;
      while (!mgo_b && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("b_mgo", 32'(mgo_b), 32'd1);
      check("b_idx", 32'(lut_index_b), 32'd0);
      check("b_data", 32'(i2c_data_b), {8'h00, 8'h34, tab_b[0]});
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      check("b_start_ignored", 32'(mgo_b), 32'd1);
      mend_b = 1'b1;
      mack_b = 1'b0;
      @(negedge clk);
      mend_b = 1'b0;
      check("b_nack_mgo", 32'(mgo_b), 32'd0);
      check("b_nack_busy", 32'(busy_b), 32'd1);
      @(negedge clk);
      check("b_reload_mgo", 32'(mgo_b), 32'd1);
      check("b_reload_idx", 32'(lut_index_b), 32'd0);
      mend_b = 1'b1;
      mack_b = 1'b1;
      @(negedge clk);
      mend_b = 1'b0;
      check("b_done", 32'(done_b), 32'd1);
      check("b_busy", 32'(busy_b), 32'd0);
      check("b_err", 32'(err_b), 32'd0);
      n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (mgo_b) n++;
      end
      check("b_no_mgo", 32'(n), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
